// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder-tree accumulator.
//   clog2     - ceiling log2, used to derive the tree depth from the lane count
//   lane_lsb  - bit offset of lane idx inside a packed bus of equal-width lanes
//   acc_state_t - accumulator group state
package adder_tree_pkg;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_OPEN = 1'b1
    } acc_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level of the adder tree.
// Adds adjacent lane pairs of a packed WIDTH-bit bus into (WIDTH+1)-bit sums,
// so the level is exact. Valid/last travel alongside in matching flops.
//   clk, reset          - clock, asynchronous active-low reset
//   in_valid, in_last   - beat qualifier and group delimiter from the level before
//   in_data             - 2*PAIRS lanes of WIDTH bits
//   out_valid, out_last - registered qualifiers
//   out_data            - PAIRS lanes of WIDTH+1 bits
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int unsigned PAIRS  = 2,
    parameter int unsigned WIDTH  = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [2*PAIRS*WIDTH-1:0]     in_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [PAIRS*(WIDTH+1)-1:0]   out_data
);

    logic [PAIRS*(WIDTH+1)-1:0] sum_d;

    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v);
        return SIGNED ? {v[WIDTH-1], v} : {1'b0, v};
    endfunction

    always_comb begin
        sum_d = '0;
        for (int unsigned p = 0; p < PAIRS; p++) begin
            sum_d[p*(WIDTH+1) +: WIDTH+1] =
                ext(in_data[lane_lsb(2*p, WIDTH) +: WIDTH]) +
                ext(in_data[lane_lsb(2*p+1, WIDTH) +: WIDTH]);
        end
    end

    // last is only meaningful on a valid beat; masking keeps bubbles clean
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_last  <= in_valid & in_last;
        end
    end

    // Data is don't-care on bubbles, so it needs neither enable nor reset.
    always_ff @(posedge clk) begin
        out_data <= sum_d;
    end

endmodule

// File: rtl/adder_tree_accum.sv
// Pipelined adder tree with group accumulator.
// Reduces NUM_INPUTS lanes of IN_WIDTH bits to one exact sum per beat through
// LEVELS registered levels, then accumulates beat sums over a group that ends
// on in_last, wrapping modulo 2^OUT_WIDTH with a sticky overflow flag.
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   in_valid     - beat qualifier
//   in_last      - final beat of a group (ignored without in_valid)
//   in_data      - packed lanes, lane i at [i*IN_WIDTH +: IN_WIDTH]
//   out_valid    - one-cycle pulse per completed group
//   out_sum      - group sum, held until the next group completes
//   out_overflow - group result exceeded the OUT_WIDTH range
module adder_tree_accum
    import adder_tree_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned IN_WIDTH   = 4,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter bit          SIGNED     = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           in_last,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0] in_data,
    output logic                           out_valid,
    output logic [OUT_WIDTH-1:0]           out_sum,
    output logic                           out_overflow
);

    localparam int unsigned LEVELS = clog2(NUM_INPUTS);
    localparam int unsigned TREE_W = IN_WIDTH + LEVELS;

    // Boundary register on the inputs; together with the LEVELS tree levels
    // and the accumulator flop this gives the LEVELS+1 edge latency.
    logic                           in_v_q;
    logic                           in_l_q;
    logic [NUM_INPUTS*IN_WIDTH-1:0] in_d_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_v_q <= 1'b0;
            in_l_q <= 1'b0;
        end else begin
            in_v_q <= in_valid;
            in_l_q <= in_valid & in_last;
        end
    end

    always_ff @(posedge clk) begin
        in_d_q <= in_data;
    end

    // Each level lives in its own generate scope so its buses carry their
    // exact width; level k reads level k-1 through the scope name.
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned PAIRS = NUM_INPUTS >> (k + 1);
        localparam int unsigned W     = IN_WIDTH + k;

        logic                     v_in;
        logic                     l_in;
        logic [2*PAIRS*W-1:0]     d_in;
        logic                     v_out;
        logic                     l_out;
        logic [PAIRS*(W+1)-1:0]   d_out;

        if (k == 0) begin : g_src
            assign v_in = in_v_q;
            assign l_in = in_l_q;
            assign d_in = in_d_q;
        end else begin : g_src
            assign v_in = g_lvl[k-1].v_out;
            assign l_in = g_lvl[k-1].l_out;
            assign d_in = g_lvl[k-1].d_out;
        end

        adder_tree_level #(
            .PAIRS  (PAIRS),
            .WIDTH  (W),
            .SIGNED (SIGNED)
        ) u_level (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (v_in),
            .in_last   (l_in),
            .in_data   (d_in),
            .out_valid (v_out),
            .out_last  (l_out),
            .out_data  (d_out)
        );
    end

    logic              tree_valid;
    logic              tree_last;
    logic [TREE_W-1:0] tree_sum;

    assign tree_valid = g_lvl[LEVELS-1].v_out;
    assign tree_last  = g_lvl[LEVELS-1].l_out;
    assign tree_sum   = g_lvl[LEVELS-1].d_out;

    // Accumulator
    acc_state_t           state, state_n;
    logic [OUT_WIDTH-1:0] acc, acc_n;
    logic                 grp_ovf, grp_ovf_n;
    logic                 out_valid_n;
    logic [OUT_WIDTH-1:0] out_sum_n;
    logic                 out_ovf_n;

    logic [OUT_WIDTH-1:0] tree_ext;
    logic [OUT_WIDTH:0]   add_full;
    logic                 add_ovf;

    always_comb begin
        if (SIGNED) begin
            tree_ext = OUT_WIDTH'($signed(tree_sum));
        end else begin
            tree_ext = OUT_WIDTH'(tree_sum);
        end
    end

    always_comb begin
        add_full = {1'b0, acc} + {1'b0, tree_ext};
        if (SIGNED) begin
            add_ovf = (acc[OUT_WIDTH-1] == tree_ext[OUT_WIDTH-1]) &&
                      (add_full[OUT_WIDTH-1] != acc[OUT_WIDTH-1]);
        end else begin
            add_ovf = add_full[OUT_WIDTH];
        end
    end

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        grp_ovf_n   = grp_ovf;
        out_valid_n = 1'b0;
        out_sum_n   = out_sum;
        out_ovf_n   = out_overflow;
        if (tree_valid) begin
            unique case (state)
                ACC_IDLE: begin
                    if (tree_last) begin
                        out_valid_n = 1'b1;
                        out_sum_n   = tree_ext;
                        out_ovf_n   = 1'b0;
                    end else begin
                        acc_n     = tree_ext;
                        grp_ovf_n = 1'b0;
                        state_n   = ACC_OPEN;
                    end
                end
                ACC_OPEN: begin
                    if (tree_last) begin
                        out_valid_n = 1'b1;
                        out_sum_n   = add_full[OUT_WIDTH-1:0];
                        out_ovf_n   = grp_ovf | add_ovf;
                        grp_ovf_n   = 1'b0;
                        state_n     = ACC_IDLE;
                    end else begin
                        acc_n     = add_full[OUT_WIDTH-1:0];
                        grp_ovf_n = grp_ovf | add_ovf;
                    end
                end
                default: state_n = ACC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ACC_IDLE;
            acc          <= '0;
            grp_ovf      <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            grp_ovf      <= grp_ovf_n;
            out_valid    <= out_valid_n;
            out_sum      <= out_sum_n;
            out_overflow <= out_ovf_n;
        end
    end

endmodule

// File: tb/tb_adder_tree_accum.sv
`timescale 1ns/1ps
module tb_adder_tree_accum;

    // Three configurations: 0 = default unsigned, 1 = signed, 2 = 8 lanes x 6 bits
    typedef int lanes_t [8];
    typedef struct {
        longint sum;
        bit     ovf;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic        v0, v1, v2;
    logic        l0, l1, l2;
    logic [15:0] d0, d1;
    logic [47:0] d2;
    logic        ov0, ov1, ov2;
    logic        oo0, oo1, oo2;
    logic [7:0]  s0, s1;
    logic [11:0] s2;

    adder_tree_accum u_dut0 (
        .clk(clk), .reset(reset), .in_valid(v0), .in_last(l0), .in_data(d0),
        .out_valid(ov0), .out_sum(s0), .out_overflow(oo0)
    );

    adder_tree_accum #(
        .NUM_INPUTS(4), .IN_WIDTH(4), .OUT_WIDTH(8), .SIGNED(1'b1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_last(l1), .in_data(d1),
        .out_valid(ov1), .out_sum(s1), .out_overflow(oo1)
    );

    adder_tree_accum #(
        .NUM_INPUTS(8), .IN_WIDTH(6), .OUT_WIDTH(12), .SIGNED(1'b0)
    ) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_last(l2), .in_data(d2),
        .out_valid(ov2), .out_sum(s2), .out_overflow(oo2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    longint m_acc  [3];
    bit     m_open [3];
    bit     m_ovf  [3];

    function automatic int ni(input int k); return (k == 2) ? 8 : 4; endfunction
    function automatic int iw(input int k); return (k == 2) ? 6 : 4; endfunction
    function automatic int ow(input int k); return (k == 2) ? 12 : 8; endfunction
    function automatic int lv(input int k); return (k == 2) ? 3 : 2; endfunction
    function automatic bit sg(input int k); return (k == 1); endfunction

    // Value of a raw lane pattern under the configuration's signedness
    function automatic longint lane_val(input int k, input int raw);
        int h;
        int r;
        h = 1 << iw(k);
        r = raw & (h - 1);
        if (sg(k) && r >= h / 2) return longint'(r - h);
        return longint'(r);
    endfunction

    // Fold an exact integer into the OUT_WIDTH value range
    function automatic longint wrap(input int k, input longint x);
        longint m;
        longint r;
        m = longint'(1) << ow(k);
        r = x % m;
        if (r < 0) r = r + m;
        if (sg(k) && r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic bit in_range(input int k, input longint x);
        longint m;
        m = longint'(1) << ow(k);
        if (sg(k)) return (x >= -(m / 2)) && (x < m / 2);
        return (x >= 0) && (x < m);
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qhead(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic push_exp(input int k, input longint val, input bit ovf);
        exp_t e;
        e.sum = val & ((longint'(1) << ow(k)) - 1);
        e.ovf = ovf;
        // driven now, sampled at the next edge, result after LEVELS+1 more edges
        e.cyc = cyc + lv(k) + 2;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Advance to the next falling edge with every input idle
    task automatic next();
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        l0 = 1'b0; l1 = 1'b0; l2 = 1'b0;
    endtask

    // Present one valid beat on DUT k and update the reference model
    task automatic drive(input int k, input bit last, input lanes_t lanes);
        logic [63:0] bus;
        longint      s;
        longint      e;
        bus = '0;
        s   = 0;
        for (int i = 0; i < ni(k); i++) begin
            bus = bus | ((64'(lanes[i]) & ((64'd1 << iw(k)) - 64'd1)) << (i * iw(k)));
            s   = s + lane_val(k, lanes[i]);
        end
        case (k)
            0:       begin v0 = 1'b1; l0 = last; d0 = bus[15:0]; end
            1:       begin v1 = 1'b1; l1 = last; d1 = bus[15:0]; end
            default: begin v2 = 1'b1; l2 = last; d2 = bus[47:0]; end
        endcase
        if (!m_open[k]) begin
            if (last) begin
                push_exp(k, wrap(k, s), 1'b0);
            end else begin
                m_acc[k]  = s;
                m_open[k] = 1'b1;
                m_ovf[k]  = 1'b0;
            end
        end else begin
            e = m_acc[k] + s;
            if (!in_range(k, e)) m_ovf[k] = 1'b1;
            m_acc[k] = wrap(k, e);
            if (last) begin
                push_exp(k, m_acc[k], m_ovf[k]);
                m_open[k] = 1'b0;
                m_ovf[k]  = 1'b0;
            end
        end
    endtask

    task automatic check_out(input int k, input logic vld, input longint sum, input logic ovf);
        exp_t e;
        forever begin
            if (qsize(k) == 0) break;
            e = qhead(k);
            if (e.cyc >= cyc) break;
            qpop(k);
            n_vec++;
            n_bad++;
            $display("FAIL missing_pulse dut%0d: no out_valid at cycle %0d, required sum=0x%0h ovf=%0d",
                     k, e.cyc, e.sum, e.ovf);
        end
        if (vld) begin
            n_vec++;
            if (qsize(k) == 0) begin
                n_bad++;
                $display("FAIL spurious_pulse dut%0d: out_valid at cycle %0d with sum=0x%0h, none required",
                         k, cyc, sum);
            end else begin
                e = qhead(k);
                qpop(k);
                if (sum != e.sum || ovf != e.ovf || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL group_result dut%0d: got sum=0x%0h ovf=%0d cycle=%0d, required sum=0x%0h ovf=%0d cycle=%0d",
                             k, sum, ovf, cyc, e.sum, e.ovf, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            check_out(0, ov0, longint'(s0), oo0);
            check_out(1, ov1, longint'(s1), oo1);
            check_out(2, ov2, longint'(s2), oo2);
        end
    end

    task automatic check_zero(input string tag);
        logic [2:0] vv;
        logic [2:0] oo;
        longint     ss [3];
        vv = {ov2, ov1, ov0};
        oo = {oo2, oo1, oo0};
        ss[0] = longint'(s0);
        ss[1] = longint'(s1);
        ss[2] = longint'(s2);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (vv[k] !== 1'b0 || oo[k] !== 1'b0 || ss[k] != 0) begin
                n_bad++;
                $display("FAIL %s dut%0d: got valid=%b sum=0x%0h ovf=%b, required all zero",
                         tag, k, vv[k], ss[k], oo[k]);
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_open[k] = 1'b0;
            m_ovf[k]  = 1'b0;
            m_acc[k]  = 0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lanes_t ln;
        bit     hot;
        bit     lst;

        reset = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        l0 = 1'b0; l1 = 1'b0; l2 = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        model_reset();

        @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        // single-beat group
        next(); drive(0, 1'b1, '{15, 15, 15, 15, 0, 0, 0, 0});

        // three beats with two bubbles between each
        for (int b = 0; b < 3; b++) begin
            next(); drive(0, (b == 2), '{1, 2, 3, 4, 0, 0, 0, 0});
            if (b != 2) begin next(); next(); end
        end

        // wrap with overflow, then a clean single beat
        for (int b = 0; b < 5; b++) begin
            next(); drive(0, (b == 4), '{15, 15, 15, 15, 0, 0, 0, 0});
        end
        next(); drive(0, 1'b1, '{1, 0, 0, 0, 0, 0, 0, 0});

        // signed: four beats of -8 lanes land exactly on -128, five overflow
        for (int b = 0; b < 4; b++) begin
            next(); drive(1, (b == 3), '{8, 8, 8, 8, 0, 0, 0, 0});
        end
        for (int b = 0; b < 5; b++) begin
            next(); drive(1, (b == 4), '{8, 8, 8, 8, 0, 0, 0, 0});
        end

        // wide config: back-to-back single-beat groups
        next(); drive(2, 1'b1, '{63, 63, 63, 63, 63, 63, 63, 63});
        next(); drive(2, 1'b1, '{0, 0, 0, 0, 0, 0, 0, 0});

        for (int i = 0; i < 10; i++) next();

        // reset in the middle of an open group
        next(); drive(0, 1'b0, '{1, 1, 1, 1, 0, 0, 0, 0});
        next(); drive(0, 1'b0, '{1, 1, 1, 1, 0, 0, 0, 0});
        next();
        #1 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset_midgroup");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        next(); drive(0, 1'b1, '{1, 1, 1, 1, 0, 0, 0, 0});

        // random traffic on all three configurations at once
        for (int c = 0; c < 600; c++) begin
            next();
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 9) < 7) begin
                    hot = ($urandom_range(0, 3) == 0);
                    for (int i = 0; i < 8; i++) begin
                        if (hot) ln[i] = (1 << iw(k)) - 1;
                        else     ln[i] = int'($urandom_range(0, (1 << iw(k)) - 1));
                    end
                    lst = ($urandom_range(0, 3) == 0);
                    drive(k, lst, ln);
                end
            end
        end

        for (int i = 0; i < 12; i++) next();

        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (qsize(k) != 0) begin
                n_bad++;
                $display("FAIL drain dut%0d: %0d expected pulses outstanding, required 0", k, qsize(k));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
